pos_aim: RTL and testbench
==========================

Name: pos_aim

Overview:
Player position and aim controller for the game datapath.
- Four push-button inputs step a 5-bit horizontal position and a 3-bit aim index. Each button steps once per press.
- The aim index is decoded into a shot direction flag and a run/rise slope vector.
- Downstream trajectory logic consumes run, rise and dir.

Parameters:
None. All widths and table values are fixed.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low reset; 0 = reset
- left_x  input  1  move-left button, active high
- right_x  input  1  move-right button, active high
- left_aim  input  1  aim-decrement button, active high
- right_aim  input  1  aim-increment button, active high
- x_pos  output  5  horizontal position, 0..31
- aim_pos  output  3  aim index, 0..7
- run  output  5  horizontal slope component, unsigned magnitude
- rise  output  5  vertical slope component, unsigned magnitude
- dir  output  1  shot direction: 1 = right, 0 = left

Behaviour:
- Single clock domain; the design has no other clock.
- reset is sampled only on the rising edge of clk; reset = 0 at an edge forces reset state.
- Reset state:
  - x_pos = 16, aim_pos = 4.
  - Resulting decoded outputs: dir = 1, run = 4, rise = 16.
  - All four button-history registers = 1, so a button held through reset release produces no step.
- Edge detection:
  - Each button has a history flop holding its previous-cycle value.
  - press = button & ~history.
  - History flops update every non-reset cycle.
- Latency: a press sampled at edge N updates x_pos/aim_pos at edge N; the value is visible after that edge. Holding a button gives exactly one step.
- x_pos update (one step per press):
  - left press only: decrement, saturating at 0.
  - right press only: increment, saturating at 31.
  - Both presses in the same cycle: no change.
  - No wrap-around.
- aim_pos update:
  - Same rules as x_pos, using left_aim (decrement) and right_aim (increment).
  - Saturates at 0 and 7; no wrap.
- x and aim controls are independent; presses on both in one cycle both take effect.
- Decoded outputs are purely combinational from the aim_pos register, so they are valid in the same cycle as aim_pos.
- dir = aim_pos[2].
- Steepness s (2 bits):
  - aim_pos[1:0] when dir = 0.
  - ~aim_pos[1:0] when dir = 1.
  - Index 0 is shallow-left, 3 near-vertical left, 4 near-vertical right, 7 shallow-right.
- Slope table, indexed by s:
  - s=0: run 16, rise 4
  - s=1: run 12, rise 8
  - s=2: run 8, rise 12
  - s=3: run 4, rise 16
- Reset mid-operation: reset wins over any press in the same cycle; state returns to the reset values at that edge.

Test Plan:
1. Reset: hold reset=0 for 2 cycles, then release with all buttons 0 -> x_pos=16, aim_pos=4, dir=1, run=4, rise=16.
2. Single step and hold:
   - Pulse right_x for 1 cycle -> x_pos=17.
   - Hold left_x for 10 cycles -> x_pos=16 only.
   - Release, then 3 separate left_x pulses -> x_pos=13.
3. Saturation:
   - 40 separate right_x pulses -> x_pos=31.
   - 40 left_x pulses -> x_pos=0, no wrap to 31.
   - 10 right_aim pulses -> aim_pos=7.
   - 10 left_aim pulses -> aim_pos=0.
4. Aim decode sweep: step aim_pos 0 through 7 and check (dir, run, rise) =
   (0,16,4), (0,12,8), (0,8,12), (0,4,16), (1,4,16), (1,8,12), (1,12,8), (1,16,4).
5. Simultaneous events:
   - left_x and right_x rising together -> x_pos unchanged.
   - right_x and left_aim rising together -> x_pos+1 and aim_pos-1 in the same edge.
6. Reset interactions:
   - right_x held high across reset release -> no step after release.
   - Assert reset=0 in the same cycle as a right_aim press -> aim_pos=4, x_pos=16 after that edge.

Source files
------------

// File: rtl/pos_aim.sv
// Player position and aim controller: button edge detection,
// saturating x/aim steppers and aim-to-slope decode.
module pos_aim (
   input  logic       clk,
   input  logic       reset,
   input  logic       left_x,
   input  logic       right_x,
   input  logic       left_aim,
   input  logic       right_aim,
   output logic [4:0] x_pos,
   output logic [2:0] aim_pos,
   output logic [4:0] run,
   output logic [4:0] rise,
   output logic       dir
);

   logic [3:0] btn;
   logic [3:0] hist;
   logic [3:0] press;
   logic [1:0] s;

   assign btn   = {right_aim, left_aim, right_x, left_x};
   assign press = btn & ~hist;

   // History resets high so a button held through reset gives no step
   always_ff @(posedge clk) begin
      if (!reset) begin
         x_pos   <= 5'd16;
         aim_pos <= 3'd4;
         hist    <= 4'hF;
      end else begin
         hist <= btn;
         if (press[0] && !press[1] && x_pos != 5'd0)
            x_pos <= x_pos - 5'd1;
         else if (press[1] && !press[0] && x_pos != 5'd31)
            x_pos <= x_pos + 5'd1;
         if (press[2] && !press[3] && aim_pos != 3'd0)
            aim_pos <= aim_pos - 3'd1;
         else if (press[3] && !press[2] && aim_pos != 3'd7)
            aim_pos <= aim_pos + 3'd1;
      end
   end

   assign dir = aim_pos[2];
   assign s   = dir ? ~aim_pos[1:0] : aim_pos[1:0];

   always_comb begin
      run  = 5'd16;
      rise = 5'd4;
      unique case (s)
         2'd0: begin run = 5'd16; rise = 5'd4;  end
         2'd1: begin run = 5'd12; rise = 5'd8;  end
         2'd2: begin run = 5'd8;  rise = 5'd12; end
         2'd3: begin run = 5'd4;  rise = 5'd16; end
      endcase
   end

endmodule

// File: tb/tb_pos_aim.sv
// Scoreboard bench for pos_aim: random and directed button
// sequences checked against a behavioural model.
module tb_pos_aim;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       left_x = 1'b0;
   logic       right_x = 1'b0;
   logic       left_aim = 1'b0;
   logic       right_aim = 1'b0;
   logic [4:0] x_pos;
   logic [2:0] aim_pos;
   logic [4:0] run;
   logic [4:0] rise;
   logic       dir;

   typedef struct {
      int x;
      int aim;
      int dir;
      int run;
      int rise;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   bit   done = 1'b0;

   int m_x = 16;
   int m_aim = 4;
   bit m_h[4] = '{1, 1, 1, 1};

   pos_aim dut (
      .clk       (clk),
      .reset     (reset),
      .left_x    (left_x),
      .right_x   (right_x),
      .left_aim  (left_aim),
      .right_aim (right_aim),
      .x_pos     (x_pos),
      .aim_pos   (aim_pos),
      .run       (run),
      .rise      (rise),
      .dir       (dir)
   );

   always #5 clk = ~clk;

   function automatic exp_t expect_of(int x, int aim);
      exp_t e;
      int   st;
      e.x   = x;
      e.aim = aim;
      e.dir = (aim >= 4) ? 1 : 0;
      st    = (aim < 4) ? aim : 7 - aim;
      e.run  = 16 - 4 * st;
      e.rise = 4 + 4 * st;
      return e;
   endfunction

   function automatic int clamp(int v, int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   // Behavioural model: one call per clock edge
   function automatic void model(bit r, bit lx, bit rx, bit la, bit ra);
      bit p[4];
      if (!r) begin
         m_x   = 16;
         m_aim = 4;
         m_h   = '{1, 1, 1, 1};
         return;
      end
      p[0] = lx && !m_h[0];
      p[1] = rx && !m_h[1];
      p[2] = la && !m_h[2];
      p[3] = ra && !m_h[3];
      if (p[0] != p[1]) m_x = clamp(m_x + (p[1] ? 1 : -1), 31);
      if (p[2] != p[3]) m_aim = clamp(m_aim + (p[3] ? 1 : -1), 7);
      m_h = '{lx, rx, la, ra};
   endfunction

   task automatic step(bit r, bit lx, bit rx, bit la, bit ra);
      @(negedge clk);
      reset     = r;
      left_x    = lx;
      right_x   = rx;
      left_aim  = la;
      right_aim = ra;
      model(r, lx, rx, la, ra);
      sb.push_back(expect_of(m_x, m_aim));
      @(posedge clk);
      #2;
   endtask

   task automatic pulse(bit lx, bit rx, bit la, bit ra);
      step(1, lx, rx, la, ra);
      step(1, 0, 0, 0, 0);
   endtask

   task automatic chk(string name, int x, int aim);
      exp_t e;
      e = expect_of(x, aim);
      checks++;
      if (x_pos !== x[4:0] || aim_pos !== aim[2:0] || dir !== e.dir[0]
          || run !== e.run[4:0] || rise !== e.rise[4:0]) begin
         failures++;
         $display("FAIL %s: got x=%0d aim=%0d dir=%0d run=%0d rise=%0d, want x=%0d aim=%0d dir=%0d run=%0d rise=%0d",
                  name, x_pos, aim_pos, dir, run, rise,
                  e.x, e.aim, e.dir, e.run, e.rise);
      end
   endtask

   // Monitor: outputs are valid every cycle after an edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (x_pos !== e.x[4:0] || aim_pos !== e.aim[2:0]
                || dir !== e.dir[0] || run !== e.run[4:0]
                || rise !== e.rise[4:0]) begin
               failures++;
               $display("FAIL sb t=%0t: got x=%0d aim=%0d dir=%0d run=%0d rise=%0d, want x=%0d aim=%0d dir=%0d run=%0d rise=%0d",
                        $time, x_pos, aim_pos, dir, run, rise,
                        e.x, e.aim, e.dir, e.run, e.rise);
            end
         end
      end
   end

   initial begin
      int a;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("reset", 16, 4);

      pulse(0, 1, 0, 0);
      chk("right_pulse", 17, 4);
      for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
      chk("hold_left", 16, 4);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) pulse(1, 0, 0, 0);
      chk("three_left", 13, 4);

      for (int i = 0; i < 40; i++) pulse(0, 1, 0, 0);
      chk("sat_x_hi", 31, 4);
      for (int i = 0; i < 40; i++) pulse(1, 0, 0, 0);
      chk("sat_x_lo", 0, 4);
      for (int i = 0; i < 10; i++) pulse(0, 0, 0, 1);
      chk("sat_aim_hi", 0, 7);
      for (int i = 0; i < 10; i++) pulse(0, 0, 1, 0);
      chk("sat_aim_lo", 0, 0);

      for (int i = 1; i < 8; i++) begin
         pulse(0, 0, 0, 1);
         chk($sformatf("sweep%0d", i), 0, i);
      end

      for (int i = 0; i < 5; i++) pulse(0, 1, 0, 0);
      pulse(1, 1, 0, 0);
      chk("both_x", 5, 7);
      pulse(0, 1, 1, 0);
      chk("x_and_aim", 6, 6);

      step(0, 0, 1, 0, 0);
      step(1, 0, 1, 0, 0);
      step(1, 0, 1, 0, 0);
      chk("held_thru_reset", 16, 4);
      step(1, 0, 0, 0, 0);
      pulse(0, 0, 0, 1);
      chk("aim_up", 16, 5);
      step(0, 0, 0, 0, 1);
      chk("reset_wins", 16, 4);
      step(1, 0, 0, 0, 0);

      for (int i = 0; i < 400; i++) begin
         a = $urandom_range(0, 99);
         step(a != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      end

      repeat (3) @(posedge clk);
      #3;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
